// File: rtl/mul_long_wb_if.sv
// Bundles the request side (operands and destinations) and the dual write port of the long multiplier.
// The multiplier uses the master modport and drives the register file writes; the requester uses slave.
interface mul_long_wb_if;
    logic        start;
    logic        is_signed;
    logic        accumulate;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] acc_lo;
    logic [31:0] acc_hi;
    logic [3:0]  rdlo;
    logic [3:0]  rdhi;
    logic        wb_grant;
    logic        busy;
    logic        we3;
    logic [3:0]  wa3;
    logic [31:0] wd3;
    logic [3:0]  wa4;
    logic [31:0] wd4;
    logic        long;
    logic        done;
    logic        err;

    modport master (
        input  start, is_signed, accumulate, op_a, op_b, acc_lo, acc_hi, rdlo, rdhi, wb_grant,
        output busy, we3, wa3, wd3, wa4, wd4, long, done, err
    );

    modport slave (
        output start, is_signed, accumulate, op_a, op_b, acc_lo, acc_hi, rdlo, rdhi, wb_grant,
        input  busy, we3, wa3, wd3, wa4, wd4, long, done, err
    );
endinterface

// File: rtl/mul_long_wb.sv
// Iterative 32x32->64 multiplier (UMULL/SMULL/UMLAL/SMLAL) writing RdLo/RdHi through the dual write port.
// Optional MUL_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier magnitude is zero.
module mul_long_wb #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    mul_long_wb_if.master    bus
);
    localparam int N  = 32 / BITS_PER_CYCLE;
    localparam int CW = 6;

    typedef enum logic [2:0] {IDLE, RUN, FIX, WB, DONE} state_t;

    state_t      state_reg, state_next;
    logic [63:0] mcand_reg;
    logic [31:0] mplier_reg;
    logic [63:0] prod_reg;
    logic [CW-1:0] cnt_reg;
    logic        neg_reg;
    logic        acc_en_reg;
    logic [63:0] acc_reg;
    logic [3:0]  rdlo_reg;
    logic [3:0]  rdhi_reg;
    logic        err_pend_reg;

    logic        busy_reg, we3_reg, long_reg, done_reg, err_reg;
    logic [3:0]  wa3_reg, wa4_reg;
    logic [31:0] wd3_reg, wd4_reg;

    logic [31:0] mag_a, mag_b;
    logic [63:0] pp [BITS_PER_CYCLE];
    logic [63:0] step_sum;
    logic [31:0] mplier_rem_next;
    logic        last_iter, run_exit, idle_skip;
    logic [63:0] fix_val;

    logic        wr_en, wr_long, wr_err;
    logic [3:0]  wr_wa3, wr_wa4;
    logic [31:0] wr_wd3, wr_wd4;

    assign mag_a = (bus.is_signed && bus.op_a[31]) ? (~bus.op_a + 32'd1) : bus.op_a;
    assign mag_b = (bus.is_signed && bus.op_b[31]) ? (~bus.op_b + 32'd1) : bus.op_b;

    // One shifted copy of the multiplicand per multiplier bit retired this cycle.
    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
            assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : 64'd0;
        end
    endgenerate

    always_comb begin
        step_sum = prod_reg;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            step_sum = step_sum + pp[i];
        end
    end

    assign mplier_rem_next = mplier_reg >> BITS_PER_CYCLE;
    assign last_iter       = (cnt_reg == CW'(N - 1));

`ifdef MUL_EARLY_TERM_EN
    assign run_exit  = last_iter || (mplier_rem_next == 32'd0);
    assign idle_skip = (mag_b == 32'd0);
`else
    assign run_exit  = last_iter;
    assign idle_skip = 1'b0;
`endif

    // Accumulate wraps modulo 2^64; the carry out of bit 63 is simply dropped.
    assign fix_val = (neg_reg ? (~prod_reg + 64'd1) : prod_reg) + (acc_en_reg ? acc_reg : 64'd0);

    always_comb begin
        wr_en   = 1'b1;
        wr_long = 1'b1;
        wr_err  = 1'b0;
        wr_wa3  = rdlo_reg;
        wr_wd3  = fix_val[31:0];
        wr_wa4  = rdhi_reg;
        wr_wd4  = fix_val[63:32];
        if (rdlo_reg == 4'd15 && rdhi_reg == 4'd15) begin
            wr_en   = 1'b0;
            wr_long = 1'b0;
            wr_err  = 1'b1;
            wr_wa3  = 4'h0;
            wr_wd3  = 32'h0;
            wr_wa4  = 4'h0;
            wr_wd4  = 32'h0;
        end else if (rdlo_reg == 4'd15 || rdlo_reg == rdhi_reg) begin
            // High word wins when both halves target one register or RdLo is r15.
            wr_long = 1'b0;
            wr_err  = (rdlo_reg == 4'd15);
            wr_wa3  = rdhi_reg;
            wr_wd3  = fix_val[63:32];
            wr_wa4  = 4'h0;
            wr_wd4  = 32'h0;
        end else if (rdhi_reg == 4'd15) begin
            wr_long = 1'b0;
            wr_err  = 1'b1;
            wr_wa4  = 4'h0;
            wr_wd4  = 32'h0;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (bus.start) state_next = idle_skip ? FIX : RUN;
            RUN:  if (run_exit) state_next = FIX;
            FIX:  state_next = WB;
            // No pending write means there is nothing to wait for.
            WB:   if (bus.wb_grant || !we3_reg) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            mcand_reg    <= 64'h0;
            mplier_reg   <= 32'h0;
            prod_reg     <= 64'h0;
            cnt_reg      <= '0;
            neg_reg      <= 1'b0;
            acc_en_reg   <= 1'b0;
            acc_reg      <= 64'h0;
            rdlo_reg     <= 4'h0;
            rdhi_reg     <= 4'h0;
            err_pend_reg <= 1'b0;
            busy_reg     <= 1'b0;
            we3_reg      <= 1'b0;
            wa3_reg      <= 4'h0;
            wd3_reg      <= 32'h0;
            wa4_reg      <= 4'h0;
            wd4_reg      <= 32'h0;
            long_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != IDLE);
            done_reg  <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        mcand_reg  <= {32'h0, mag_a};
                        mplier_reg <= mag_b;
                        prod_reg   <= 64'h0;
                        cnt_reg    <= '0;
                        neg_reg    <= bus.is_signed & (bus.op_a[31] ^ bus.op_b[31]);
                        acc_en_reg <= bus.accumulate;
                        acc_reg    <= {bus.acc_hi, bus.acc_lo};
                        rdlo_reg   <= bus.rdlo;
                        rdhi_reg   <= bus.rdhi;
                    end
                end
                RUN: begin
                    prod_reg   <= step_sum;
                    mcand_reg  <= mcand_reg << BITS_PER_CYCLE;
                    mplier_reg <= mplier_rem_next;
                    cnt_reg    <= cnt_reg + 1'b1;
                end
                FIX: begin
                    we3_reg      <= wr_en;
                    long_reg     <= wr_long;
                    wa3_reg      <= wr_wa3;
                    wd3_reg      <= wr_wd3;
                    wa4_reg      <= wr_wa4;
                    wd4_reg      <= wr_wd4;
                    err_pend_reg <= wr_err;
                end
                WB: begin
                    if (state_next == DONE) begin
                        we3_reg  <= 1'b0;
                        long_reg <= 1'b0;
                        wa3_reg  <= 4'h0;
                        wd3_reg  <= 32'h0;
                        wa4_reg  <= 4'h0;
                        wd4_reg  <= 32'h0;
                        done_reg <= 1'b1;
                        err_reg  <= err_pend_reg;
                    end
                end
                DONE: begin
                    err_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.we3  = we3_reg;
    assign bus.wa3  = wa3_reg;
    assign bus.wd3  = wd3_reg;
    assign bus.wa4  = wa4_reg;
    assign bus.wd4  = wd4_reg;
    assign bus.long = long_reg;
    assign bus.done = done_reg;
    assign bus.err  = err_reg;
endmodule

// File: tb/tb_mul_long_wb.sv
// Directed bench for mul_long_wb: products, accumulate wrap, grant stalls, destination rules, reset abort.
// Latency expectations follow MUL_EARLY_TERM_EN when that macro is defined.
module tb_mul_long_wb;
    localparam int BPC = 1;
    localparam int N   = 32 / BPC;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    mul_long_wb_if bus();

    mul_long_wb #(.BITS_PER_CYCLE(BPC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Cycles from presenting start to we3 visible; iters = multiplier bits up to the top set bit.
    function automatic int exp_lat(input int iters);
        int lat;
        lat = N + 2;
`ifdef MUL_EARLY_TERM_EN
        lat = iters + 2;
`endif
        if (iters < 0) lat = 0;
        return lat;
    endfunction

    task automatic issue(input logic sgn, input logic acc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] alo, input logic [31:0] ahi, input logic [3:0] rl, input logic [3:0] rh);
        bus.is_signed  = sgn;
        bus.accumulate = acc;
        bus.op_a       = a;
        bus.op_b       = b;
        bus.acc_lo     = alo;
        bus.acc_hi     = ahi;
        bus.rdlo       = rl;
        bus.rdhi       = rh;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        // Scramble inputs so the result must come from the latched copies.
        bus.is_signed  = ~sgn;
        bus.accumulate = ~acc;
        bus.op_a       = 32'hDEAD_BEEF;
        bus.op_b       = 32'h1234_5678;
        bus.acc_lo     = 32'h5555_5555;
        bus.acc_hi     = 32'hAAAA_AAAA;
        bus.rdlo       = 4'd12;
        bus.rdhi       = 4'd13;
        $display("op sgn=%0d acc=%0d a=%h b=%h acc=%h_%h rdlo=%0d rdhi=%0d", sgn, acc, a, b, ahi, alo, rl, rh);
    endtask

    task automatic wait_we3(input string tag, input int exp);
        int cnt;
        cnt = 1;
        while (bus.we3 !== 1'b1 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_lat"}, 64'(cnt), 64'(exp));
    endtask

    task automatic check_wb(input string tag, input logic lng, input logic [3:0] wa3, input logic [31:0] wd3,
                            input logic [3:0] wa4, input logic [31:0] wd4);
        check({tag, "_we3"},  64'(bus.we3),  64'(1'b1));
        check({tag, "_long"}, 64'(bus.long), 64'(lng));
        check({tag, "_wa3"},  64'(bus.wa3),  64'(wa3));
        check({tag, "_wd3"},  64'(bus.wd3),  64'(wd3));
        check({tag, "_wa4"},  64'(bus.wa4),  64'(wa4));
        check({tag, "_wd4"},  64'(bus.wd4),  64'(wd4));
        check({tag, "_busy"}, 64'(bus.busy), 64'(1'b1));
        check({tag, "_nodone"}, 64'(bus.done), 64'(1'b0));
    endtask

    task automatic finish_write(input string tag, input logic exp_err);
        @(posedge clk); #1;
        check({tag, "_done"},  64'(bus.done), 64'(1'b1));
        check({tag, "_err"},   64'(bus.err),  64'(exp_err));
        check({tag, "_we3off"}, 64'(bus.we3), 64'(1'b0));
        @(posedge clk); #1;
        check({tag, "_done1"}, 64'(bus.done), 64'(1'b0));
        check({tag, "_idle"},  64'(bus.busy), 64'(1'b0));
        $display("txn %s complete", tag);
    endtask

    initial begin
        int  cnt;
        logic seen;

        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.is_signed  = 1'b0;
        bus.accumulate = 1'b0;
        bus.op_a       = 32'h0;
        bus.op_b       = 32'h0;
        bus.acc_lo     = 32'h0;
        bus.acc_hi     = 32'h0;
        bus.rdlo       = 4'h0;
        bus.rdhi       = 4'h0;
        bus.wb_grant   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'(1'b0));
        check("rst_we3",  64'(bus.we3),  64'(1'b0));
        check("rst_wa3",  64'(bus.wa3),  64'(4'h0));
        check("rst_wd3",  64'(bus.wd3),  64'(32'h0));
        check("rst_wa4",  64'(bus.wa4),  64'(4'h0));
        check("rst_wd4",  64'(bus.wd4),  64'(32'h0));
        check("rst_long", 64'(bus.long), 64'(1'b0));
        check("rst_done", 64'(bus.done), 64'(1'b0));
        check("rst_err",  64'(bus.err),  64'(1'b0));
        reset_n = 1'b1;
        @(posedge clk); #1;

        // UMULL all-ones squared
        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'd2, 4'd3);
        wait_we3("umull", exp_lat(32));
        check_wb("umull", 1'b1, 4'd2, 32'h0000_0001, 4'd3, 32'hFFFF_FFFE);
        finish_write("umull", 1'b0);

        // SMULL -3 * 7
        issue(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'h0, 32'h0, 4'd2, 4'd3);
        wait_we3("smull_neg", exp_lat(3));
        check_wb("smull_neg", 1'b1, 4'd2, 32'hFFFF_FFEB, 4'd3, 32'hFFFF_FFFF);
        finish_write("smull_neg", 1'b0);

        // SMULL most-negative squared
        issue(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 4'd2, 4'd3);
        wait_we3("smull_min", exp_lat(32));
        check_wb("smull_min", 1'b1, 4'd2, 32'h0000_0000, 4'd3, 32'h4000_0000);
        finish_write("smull_min", 1'b0);

        // UMLAL with 64-bit wrap
        issue(1'b0, 1'b1, 32'd2, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 4'd0, 4'd1);
        wait_we3("umlal", exp_lat(2));
        check_wb("umlal", 1'b1, 4'd0, 32'h0000_0004, 4'd1, 32'h0000_0000);
        finish_write("umlal", 1'b0);

        // SMLAL: -1 * 1 + 5 = 4
        issue(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'd0, 4'd6, 4'd7);
        wait_we3("smlal", exp_lat(1));
        check_wb("smlal", 1'b1, 4'd6, 32'h0000_0004, 4'd7, 32'h0000_0000);
        finish_write("smlal", 1'b0);

        // Grant withheld for 5 cycles; a start pulse in the window must be dropped
        bus.wb_grant = 1'b0;
        issue(1'b0, 1'b0, 32'd5, 32'd6, 32'h0, 32'h0, 4'd6, 4'd7);
        wait_we3("stall", exp_lat(3));
        for (int i = 0; i < 5; i++) begin
            if (i == 1) bus.start = 1'b1;
            if (i == 2) bus.start = 1'b0;
            @(posedge clk); #1;
            check("stall_we3",  64'(bus.we3),  64'(1'b1));
            check("stall_wd3",  64'(bus.wd3),  64'(32'd30));
            check("stall_wd4",  64'(bus.wd4),  64'(32'd0));
            check("stall_done", 64'(bus.done), 64'(1'b0));
        end
        bus.start    = 1'b0;
        bus.wb_grant = 1'b1;
        finish_write("stall", 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("stall_noqueue", 64'(bus.busy), 64'(1'b0));

        // rdlo == rdhi: high word through port 3 only
        issue(1'b0, 1'b0, 32'h0001_0001, 32'h0003_0000, 32'h0, 32'h0, 4'd4, 4'd4);
        wait_we3("same", exp_lat(18));
        check_wb("same", 1'b0, 4'd4, 32'h0000_0003, 4'd0, 32'h0);
        finish_write("same", 1'b0);

        // RdLo is r15: high word to r5, err
        issue(1'b0, 1'b0, 32'h0001_0001, 32'h0003_0000, 32'h0, 32'h0, 4'd15, 4'd5);
        wait_we3("lo15", exp_lat(18));
        check_wb("lo15", 1'b0, 4'd5, 32'h0000_0003, 4'd0, 32'h0);
        finish_write("lo15", 1'b1);

        // RdHi is r15: low word to r5, err
        issue(1'b0, 1'b0, 32'h0001_0001, 32'h0003_0000, 32'h0, 32'h0, 4'd5, 4'd15);
        wait_we3("hi15", exp_lat(18));
        check_wb("hi15", 1'b0, 4'd5, 32'h0003_0000, 4'd0, 32'h0);
        finish_write("hi15", 1'b1);

        // Both r15: no write, no grant wait even with grant low
        bus.wb_grant = 1'b0;
        issue(1'b0, 1'b0, 32'h0001_0001, 32'h0003_0000, 32'h0, 32'h0, 4'd15, 4'd15);
        cnt  = 1;
        seen = 1'b0;
        while (bus.done !== 1'b1 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (bus.we3 === 1'b1) seen = 1'b1;
        end
        check("both15_lat", 64'(cnt), 64'(exp_lat(18) + 1));
        check("both15_nowe", 64'(seen), 64'(1'b0));
        check("both15_err", 64'(bus.err), 64'(1'b1));
        @(posedge clk); #1;
        check("both15_idle", 64'(bus.busy), 64'(1'b0));
        $display("txn both15 complete");
        bus.wb_grant = 1'b1;

        // Asynchronous reset in the middle of RUN
        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'd8, 4'd9);
        repeat (10) @(posedge clk);
        #1;
        check("abort_busy_pre", 64'(bus.busy), 64'(1'b1));
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'(1'b0));
        check("abort_we3",  64'(bus.we3),  64'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < N + 8; i++) begin
            @(posedge clk); #1;
            if (bus.we3 === 1'b1 || bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        check("abort_quiet", 64'(seen), 64'(1'b0));
        $display("txn abort complete");

        issue(1'b0, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0, 32'h0, 4'd10, 4'd11);
        wait_we3("fresh", exp_lat(5));
        check_wb("fresh", 1'b1, 4'd10, 32'h2345_6780, 4'd11, 32'h0000_0001);
        finish_write("fresh", 1'b0);

        // Zero multiplier: shortest path when early termination is built in
        issue(1'b1, 1'b0, 32'h8765_4321, 32'h0, 32'h0, 32'h0, 4'd1, 4'd2);
        wait_we3("zero", exp_lat(0));
        check_wb("zero", 1'b1, 4'd1, 32'h0, 4'd2, 32'h0);
        finish_write("zero", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
